// File: rtl/cd_sector_feeder.sv
// cd_sector_feeder: paces CD sector delivery at 1x/2x, requests each sector
// from the HPS by LBA, streams the received words into the sector buffer RAM
// and announces each finished sector with BCD MSF + MSF_LATCH + SECTOR_READY.
module cd_sector_feeder #(
  parameter int unsigned SECTOR_PERIOD = 160000,
  parameter int unsigned SECTOR_WORDS  = 1024,
  parameter int unsigned LBA_OFFSET    = 150
) (
  input  logic        CLK_12M,
  input  logic        nRESET,
  input  logic        PLAY,
  input  logic        SPEED_2X,
  input  logic        LBA_LOAD,
  input  logic [18:0] LBA_START,
  output logic        BUSY,
  output logic        REQ,
  output logic [18:0] REQ_LBA,
  input  logic        HOST_ACK,
  input  logic        DIN_VALID,
  input  logic [15:0] DIN,
  input  logic        BUF_LOCK,
  output logic        BUF_WE,
  output logic [9:0]  BUF_ADDR,
  output logic [15:0] BUF_DATA,
  output logic [7:0]  MSF_M,
  output logic [7:0]  MSF_S,
  output logic [7:0]  MSF_F,
  output logic        MSF_LATCH,
  output logic        SECTOR_READY,
  output logic        OVERRUN,
  input  logic        OVR_CLR
);

  localparam int unsigned CNT_W = $clog2(SECTOR_PERIOD + 1);
  localparam logic [CNT_W-1:0] LOAD_1X   = CNT_W'(SECTOR_PERIOD - 1);
  localparam logic [CNT_W-1:0] LOAD_2X   = CNT_W'(SECTOR_PERIOD / 2 - 1);
  localparam logic [9:0]       LAST_WORD = 10'(SECTOR_WORDS - 1);
  localparam logic [19:0]      FR_MIN    = 20'd4500;
  localparam logic [19:0]      FR_SEC    = 20'd75;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONV      = 3'd1,
    S_WAIT_TICK = 3'd2,
    S_REQUEST   = 3'd3,
    S_RECEIVE   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Binary 0..99 to two BCD digits.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v - (7'(tens) * 7'd10));
    return {tens, ones};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [18:0]      r_lba;
  logic [19:0]      r_rem;
  logic [6:0]       r_m;
  logic [6:0]       r_s;
  logic [6:0]       r_f;
  logic [9:0]       r_wcnt;
  logic             r_done_ph;
  logic             r_busy;
  logic             r_req;
  logic [18:0]      r_req_lba;
  logic             r_buf_we;
  logic [9:0]       r_buf_addr;
  logic [15:0]      r_buf_data;
  logic [7:0]       r_msf_m;
  logic [7:0]       r_msf_s;
  logic [7:0]       r_msf_f;
  logic             r_msf_latch;
  logic             r_sector_ready;
  logic             r_overrun;

  logic w_active;
  logic w_run;
  logic w_abort;
  logic w_tick;
  logic w_load;
  logic w_start;
  logic w_conv_min;
  logic w_conv_sec;
  logic w_conv_end;
  logic w_req_set;
  logic w_ack;
  logic w_wr;
  logic w_latch;
  logic w_ready;
  logic w_ovr_set;

  // Control strobes derived from the current state and inputs.
  always_comb begin
    w_active   = (r_state == S_WAIT_TICK) || (r_state == S_REQUEST) ||
                 (r_state == S_RECEIVE)   || (r_state == S_DONE);
    w_run      = w_active && PLAY;
    w_abort    = w_active && !PLAY;
    w_tick     = w_run && (r_tick_cnt == '0);
    w_load     = (r_state == S_IDLE) && LBA_LOAD;
    w_start    = (r_state == S_IDLE) && !LBA_LOAD && PLAY;
    w_conv_min = (r_state == S_CONV) && (r_rem >= FR_MIN);
    w_conv_sec = (r_state == S_CONV) && (r_rem < FR_MIN) && (r_rem >= FR_SEC);
    w_conv_end = (r_state == S_CONV) && (r_rem < FR_SEC);
    w_req_set  = (r_state == S_WAIT_TICK) && w_tick && !BUF_LOCK;
    w_ack      = (r_state == S_REQUEST) && PLAY && HOST_ACK;
    w_wr       = (r_state == S_RECEIVE) && PLAY && DIN_VALID;
    w_latch    = (r_state == S_DONE) && PLAY && !r_done_ph;
    w_ready    = (r_state == S_DONE) && PLAY && r_done_ph;
    // A tick outside WAIT_TICK means the slot was missed; in WAIT_TICK only a locked buffer misses it.
    w_ovr_set  = w_tick && ((r_state != S_WAIT_TICK) || BUF_LOCK);
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (LBA_LOAD)  w_state_nxt = S_CONV;
        else if (PLAY) w_state_nxt = S_WAIT_TICK;
        else           w_state_nxt = S_IDLE;
      end
      S_CONV: begin
        if (w_conv_end) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_CONV;
      end
      S_WAIT_TICK: begin
        if (w_abort)        w_state_nxt = S_IDLE;
        else if (w_req_set) w_state_nxt = S_REQUEST;
        else                w_state_nxt = S_WAIT_TICK;
      end
      S_REQUEST: begin
        if (w_abort)    w_state_nxt = S_IDLE;
        else if (w_ack) w_state_nxt = S_RECEIVE;
        else            w_state_nxt = S_REQUEST;
      end
      S_RECEIVE: begin
        if (w_abort)                           w_state_nxt = S_IDLE;
        else if (w_wr && (r_wcnt == LAST_WORD)) w_state_nxt = S_DONE;
        else                                   w_state_nxt = S_RECEIVE;
      end
      S_DONE: begin
        if (w_abort)      w_state_nxt = S_IDLE;
        else if (w_ready) w_state_nxt = S_WAIT_TICK;
        else              w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_12M) begin
    if (!nRESET) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Sector pacing counter; the speed setting is sampled only at (re)load.
  always_ff @(posedge CLK_12M) begin
    if (!nRESET)                              r_tick_cnt <= '0;
    else if (w_start || (w_run && (r_tick_cnt == '0))) r_tick_cnt <= SPEED_2X ? LOAD_2X : LOAD_1X;
    else if (w_run)                           r_tick_cnt <= r_tick_cnt - 1'b1;
    else                                      r_tick_cnt <= r_tick_cnt;
  end

  // LBA, LBA-to-MSF conversion by repeated subtraction, and per-sector MSF advance.
  always_ff @(posedge CLK_12M) begin
    if (!nRESET) begin
      r_lba  <= 19'd0;
      r_rem  <= 20'd0;
      r_m    <= 7'd0;
      r_s    <= 7'd0;
      r_f    <= 7'd0;
      r_busy <= 1'b0;
    end else if (w_load) begin
      r_lba  <= LBA_START;
      r_rem  <= 20'(LBA_START) + 20'(LBA_OFFSET);
      r_m    <= 7'd0;
      r_s    <= 7'd0;
      r_f    <= 7'd0;
      r_busy <= 1'b1;
    end else if (w_conv_min) begin
      r_rem <= r_rem - FR_MIN;
      r_m   <= (r_m == 7'd99) ? 7'd0 : r_m + 7'd1;
    end else if (w_conv_sec) begin
      r_rem <= r_rem - FR_SEC;
      r_s   <= r_s + 7'd1;
    end else if (w_conv_end) begin
      r_f    <= r_rem[6:0];
      r_busy <= 1'b0;
    end else if (w_ready) begin
      r_lba <= r_lba + 19'd1;
      if (r_f == 7'd74) begin
        r_f <= 7'd0;
        if (r_s == 7'd59) begin
          r_s <= 7'd0;
          r_m <= (r_m == 7'd99) ? 7'd0 : r_m + 7'd1;
        end else begin
          r_s <= r_s + 7'd1;
        end
      end else begin
        r_f <= r_f + 7'd1;
      end
    end else begin
      r_lba <= r_lba;
    end
  end

  // Host request handshake.
  always_ff @(posedge CLK_12M) begin
    if (!nRESET) begin
      r_req     <= 1'b0;
      r_req_lba <= 19'd0;
    end else if (w_req_set) begin
      r_req     <= 1'b1;
      r_req_lba <= r_lba;
    end else if (w_ack || w_abort) begin
      r_req     <= 1'b0;
    end else begin
      r_req     <= r_req;
    end
  end

  // Buffer write port: one-cycle registered copy of each accepted word.
  always_ff @(posedge CLK_12M) begin
    if (!nRESET) begin
      r_wcnt     <= 10'd0;
      r_buf_we   <= 1'b0;
      r_buf_addr <= 10'd0;
      r_buf_data <= 16'd0;
    end else begin
      r_buf_we <= w_wr;
      if (w_ack) begin
        r_wcnt <= 10'd0;
      end else if (w_wr) begin
        r_wcnt     <= r_wcnt + 10'd1;
        r_buf_addr <= r_wcnt;
        r_buf_data <= DIN;
      end else begin
        r_wcnt <= r_wcnt;
      end
    end
  end

  // Sector completion: BCD MSF latch, then ready pulse on the following cycle.
  always_ff @(posedge CLK_12M) begin
    if (!nRESET) begin
      r_done_ph      <= 1'b0;
      r_msf_m        <= 8'h00;
      r_msf_s        <= 8'h00;
      r_msf_f        <= 8'h00;
      r_msf_latch    <= 1'b0;
      r_sector_ready <= 1'b0;
    end else begin
      r_done_ph      <= w_latch;
      r_msf_latch    <= w_latch;
      r_sector_ready <= w_ready;
      if (w_latch) begin
        r_msf_m <= to_bcd(r_m);
        r_msf_s <= to_bcd(r_s);
        r_msf_f <= to_bcd(r_f);
      end else begin
        r_msf_m <= r_msf_m;
      end
    end
  end

  // Sticky overrun flag; a set in the same cycle as a clear wins.
  always_ff @(posedge CLK_12M) begin
    if (!nRESET)        r_overrun <= 1'b0;
    else if (w_ovr_set) r_overrun <= 1'b1;
    else if (OVR_CLR)   r_overrun <= 1'b0;
    else                r_overrun <= r_overrun;
  end

  assign BUSY         = r_busy;
  assign REQ          = r_req;
  assign REQ_LBA      = r_req_lba;
  assign BUF_WE       = r_buf_we;
  assign BUF_ADDR     = r_buf_addr;
  assign BUF_DATA     = r_buf_data;
  assign MSF_M        = r_msf_m;
  assign MSF_S        = r_msf_s;
  assign MSF_F        = r_msf_f;
  assign MSF_LATCH    = r_msf_latch;
  assign SECTOR_READY = r_sector_ready;
  assign OVERRUN      = r_overrun;

endmodule

// File: tb/tb_cd_sector_feeder.sv
// Directed bench for cd_sector_feeder with a short sector period of 200 cycles.
module tb_cd_sector_feeder;

  logic        clk = 1'b0;
  logic        nRESET, PLAY, SPEED_2X, LBA_LOAD, HOST_ACK, DIN_VALID, BUF_LOCK, OVR_CLR;
  logic [18:0] LBA_START;
  logic [15:0] DIN;
  logic        BUSY, REQ, BUF_WE, MSF_LATCH, SECTOR_READY, OVERRUN;
  logic [18:0] REQ_LBA;
  logic [9:0]  BUF_ADDR;
  logic [15:0] BUF_DATA;
  logic [7:0]  MSF_M, MSF_S, MSF_F;

  int checks = 0;
  int errors = 0;

  cd_sector_feeder #(.SECTOR_PERIOD(200), .SECTOR_WORDS(1024), .LBA_OFFSET(150)) dut (
    .CLK_12M(clk), .nRESET(nRESET), .PLAY(PLAY), .SPEED_2X(SPEED_2X),
    .LBA_LOAD(LBA_LOAD), .LBA_START(LBA_START), .BUSY(BUSY), .REQ(REQ),
    .REQ_LBA(REQ_LBA), .HOST_ACK(HOST_ACK), .DIN_VALID(DIN_VALID), .DIN(DIN),
    .BUF_LOCK(BUF_LOCK), .BUF_WE(BUF_WE), .BUF_ADDR(BUF_ADDR), .BUF_DATA(BUF_DATA),
    .MSF_M(MSF_M), .MSF_S(MSF_S), .MSF_F(MSF_F), .MSF_LATCH(MSF_LATCH),
    .SECTOR_READY(SECTOR_READY), .OVERRUN(OVERRUN), .OVR_CLR(OVR_CLR)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_req"}, 32'(REQ), 32'd0);
    chk({p, "_req_lba"}, 32'(REQ_LBA), 32'd0);
    chk({p, "_we"}, 32'(BUF_WE), 32'd0);
    chk({p, "_addr"}, 32'(BUF_ADDR), 32'd0);
    chk({p, "_data"}, 32'(BUF_DATA), 32'd0);
    chk({p, "_msf"}, {8'd0, MSF_M, MSF_S, MSF_F}, 32'd0);
    chk({p, "_pulses"}, {30'd0, MSF_LATCH, SECTOR_READY}, 32'd0);
    chk({p, "_ovr_busy"}, {30'd0, OVERRUN, BUSY}, 32'd0);
  endtask

  task automatic wait_req(input int maxc, output int n);
    n = 0;
    while (REQ !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic wait_busy_low(input int maxc, output int n);
    n = 0;
    while (BUSY !== 1'b0 && n < maxc) begin
      step();
      n++;
    end
  endtask

  // Feed nw consecutive words base+i; counts writes that do not appear 1:1 a cycle later.
  task automatic feed(input int nw, input logic [15:0] base, output int bad);
    bad = 0;
    for (int i = 0; i < nw; i++) begin
      DIN_VALID = 1'b1;
      DIN = base + 16'(i);
      step();
      if (BUF_WE !== 1'b1 || BUF_ADDR !== 10'(i) || BUF_DATA !== base + 16'(i)) bad++;
    end
    DIN_VALID = 1'b0;
  endtask

  // Full sector: request with expected LBA, ack, 1024 words, MSF latch then ready.
  task automatic do_sector(input string t, input logic [18:0] lba, input logic [7:0] m,
                           input logic [7:0] s, input logic [7:0] f, input logic [15:0] base);
    int n;
    int bad;
    wait_req(500, n);
    chk({t, "_req"}, 32'(REQ), 32'd1);
    chk({t, "_req_lba"}, 32'(REQ_LBA), 32'(lba));
    HOST_ACK = 1'b1;
    step();
    HOST_ACK = 1'b0;
    chk({t, "_req_drop"}, 32'(REQ), 32'd0);
    feed(1024, base, bad);
    chk({t, "_buf_track"}, 32'(bad), 32'd0);
    step();
    chk({t, "_latch"}, {7'd0, MSF_LATCH, MSF_M, MSF_S, MSF_F}, {7'd0, 1'b1, m, s, f});
    chk({t, "_latch_rdy0"}, 32'(SECTOR_READY), 32'd0);
    step();
    chk({t, "_ready"}, {30'd0, SECTOR_READY, MSF_LATCH}, 32'd2);
  endtask

  initial begin
    int n;
    int bad;
    int spur;
    nRESET = 1'b0; PLAY = 1'b0; SPEED_2X = 1'b0; LBA_LOAD = 1'b0; LBA_START = 19'd0;
    HOST_ACK = 1'b0; DIN_VALID = 1'b0; DIN = 16'd0; BUF_LOCK = 1'b0; OVR_CLR = 1'b0;
    step(); step(); step();
    chk_zero("rst");
    nRESET = 1'b1;
    step();

    // LBA 0 -> 150 frames -> 00:02:00; two subtractions then finish.
    LBA_LOAD = 1'b1; LBA_START = 19'd0;
    step();
    LBA_LOAD = 1'b0;
    chk("conv0_busy", 32'(BUSY), 32'd1);
    wait_busy_low(300, n);
    chk("conv0_cycles", 32'(n), 32'd3);
    PLAY = 1'b1;
    wait_req(400, n);
    chk("first_req_delay", 32'(n), 32'd201);
    do_sector("s0", 19'd0, 8'h00, 8'h02, 8'h00, 16'h0000);
    chk("ovr_slow_rx", 32'(OVERRUN), 32'd1);
    OVR_CLR = 1'b1;
    step();
    OVR_CLR = 1'b0;
    chk("ovr_clr", 32'(OVERRUN), 32'd0);

    // Abort after 500 words of LBA 1.
    wait_req(500, n);
    chk("s1_req_lba", 32'(REQ_LBA), 32'd1);
    HOST_ACK = 1'b1;
    step();
    HOST_ACK = 1'b0;
    feed(500, 16'h1000, bad);
    chk("abort_track", 32'(bad), 32'd0);
    PLAY = 1'b0; DIN_VALID = 1'b1; DIN = 16'hBEEF;
    step();
    chk("abort_we_req", {30'd0, BUF_WE, REQ}, 32'd0);
    spur = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (BUF_WE || REQ || MSF_LATCH || SECTOR_READY) spur++;
    end
    DIN_VALID = 1'b0;
    chk("abort_quiet", 32'(spur), 32'd0);
    PLAY = 1'b1;
    wait_req(400, n);
    chk("replay_delay", 32'(n), 32'd201);
    chk("replay_lba", 32'(REQ_LBA), 32'd1);

    // Locked buffer at tick: no request, overrun, same LBA on next tick.
    PLAY = 1'b0;
    step();
    chk("drop_req", 32'(REQ), 32'd0);
    OVR_CLR = 1'b1;
    step();
    OVR_CLR = 1'b0;
    BUF_LOCK = 1'b1; PLAY = 1'b1;
    spur = 0;
    for (int k = 0; k < 201; k++) begin
      LBA_LOAD = (k == 5) ? 1'b1 : 1'b0;
      LBA_START = 19'd77;
      step();
      if (REQ || BUSY) spur++;
    end
    LBA_LOAD = 1'b0;
    chk("lock_no_req", 32'(spur), 32'd0);
    chk("lock_ovr", 32'(OVERRUN), 32'd1);
    BUF_LOCK = 1'b0;
    wait_req(400, n);
    chk("lock_retry_delay", 32'(n), 32'd200);
    chk("lock_retry_lba", 32'(REQ_LBA), 32'd1);

    // LBA 4349 -> 4499 frames -> 00:59:74, then rollover to 01:00:00.
    PLAY = 1'b0;
    step();
    LBA_LOAD = 1'b1; LBA_START = 19'd4349;
    step();
    LBA_LOAD = 1'b0;
    wait_busy_low(300, n);
    chk("conv4349_cycles", 32'(n), 32'd60);
    SPEED_2X = 1'b1; PLAY = 1'b1;
    wait_req(400, n);
    chk("req_delay_2x", 32'(n), 32'd101);
    SPEED_2X = 1'b0;
    do_sector("s4349", 19'd4349, 8'h00, 8'h59, 8'h74, 16'h5A00);
    do_sector("s4350", 19'd4350, 8'h01, 8'h00, 8'h00, 16'hC3C0);

    // Reset in the middle of a sector.
    wait_req(500, n);
    chk("s4351_req_lba", 32'(REQ_LBA), 32'd4351);
    HOST_ACK = 1'b1;
    step();
    HOST_ACK = 1'b0;
    feed(10, 16'h7700, bad);
    DIN_VALID = 1'b1;
    nRESET = 1'b0; PLAY = 1'b0;
    step();
    chk_zero("midrst");
    nRESET = 1'b1; DIN_VALID = 1'b0;
    spur = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (REQ || BUF_WE || MSF_LATCH || SECTOR_READY || BUSY) spur++;
    end
    chk("midrst_quiet", 32'(spur), 32'd0);
    PLAY = 1'b1;
    wait_req(400, n);
    chk("postrst_delay", 32'(n), 32'd201);
    chk("postrst_lba", 32'(REQ_LBA), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
